block_packer: RTL and testbench
===============================

BLOCK_PACKER -- requirements
Module: block_packer

Interface
REQ-001 SHALL have parameter KEY_W, default 32, meaning modulus/block width in bits (range 8..64).
REQ-002 SHALL have parameter BYTE_W, default 8, meaning width of each received data word.
REQ-003 SHALL have parameter LEN_W, default $clog2(KEY_W+1), meaning width of the length fields.
REQ-004 SHALL have clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have rst  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have start  in  1  begin one message; sampled only in IDLE.
REQ-007 SHALL have n_key  in  KEY_W  modulus; captured in IDLE on start.
REQ-008 SHALL have ready_in, eot_in  in  1 each  RX byte-valid and end-of-text flags (levels).
REQ-009 SHALL have data_in  in  BYTE_W  RX byte.
REQ-010 SHALL have fme_ready  in  1  exponentiator can accept a block.
REQ-011 SHALL have clear_rx_flag  out  1  one-cycle pulse acknowledging RX flag.
REQ-012 SHALL have start_out  out  1  one-cycle pulse when sizing completes.
REQ-013 SHALL have n_len_out  out  LEN_W  bit length of n_key; blk_len_out  out  LEN_W  equal to n_len_out-1.
REQ-014 SHALL have fme_start  out  1, fme_data  out  KEY_W  block handoff.
REQ-015 SHALL have busy, done, err  out  1 each  not-IDLE level, end-of-message pulse, bad-key pulse.

Function
REQ-016 SHALL implement states IDLE, SIZING, PACK, ISSUE.
REQ-017 IDLE: on start SHALL capture n_key, clear n_len, pulse clear_rx_flag, go SIZING; start outside IDLE ignored.
REQ-018 SIZING: SHALL shift key buffer right one bit/cycle incrementing n_len while buffer nonzero; n_len = floor(log2(n_key))+1.
REQ-019 SIZING exit: start_out pulses n_len cycles after the start-sampling edge; if n_len < 2 SHALL pulse err and return IDLE instead of PACK.
REQ-020 Block length L = n_len-1 bits, so every block value < n_key; bits of fme_data above L-1 SHALL be zero.
REQ-021 PACK: one bit consumed per cycle from a BYTE_W byte buffer; bit counter 0..L.
REQ-022 Byte buffer empty and ready_in high: SHALL load data_in, pulse clear_rx_flag, consume its first bit that cycle.
REQ-023 ready_in and eot_in both high with empty buffer: byte SHALL be taken first; eot re-sampled when buffer next empty.
REQ-024 Byte buffer empty, eot_in high, ready_in low: SHALL pulse clear_rx_flag, set eot flag; if bit counter > 0 go ISSUE (padded), else pulse done, go IDLE.
REQ-025 Counter reaching L: go ISSUE; unconsumed byte bits SHALL be retained for the next block.
REQ-026 Padding: unfilled block positions SHALL be zero, applied in one cycle (no per-bit padding).
REQ-027 ISSUE: SHALL hold fme_data stable, wait for fme_ready, then pulse fme_start one cycle; next PACK (counter cleared) or, if eot flag set, pulse done, clear flag, IDLE.
REQ-028 fme_data SHALL remain stable from fme_start until the next fme_start.
REQ-029 Default bit order LSB-first: j-th consumed bit lands in block bit j; byte bits consumed bit0 first.

Reset
REQ-030 rst low SHALL immediately force IDLE, clear all counters, buffers, eot flag, fme_data, n_len_out, and all outputs to 0, including mid-PACK or mid-ISSUE.
REQ-031 After rst deasserts, the first start SHALL be handled as from power-up.

Configuration
REQ-032 Macro BLOCK_PACKER_MSB_FIRST_EN defined: byte bits consumed bit BYTE_W-1 first; j-th consumed bit lands in block bit L-1-j; padding zeros at low end.
REQ-033 Macro undefined: LSB-first order of REQ-029; no other behaviour differs.

Verification
REQ-034 n_key=0x000000FF, start -> n_len_out=8, blk_len_out=7, start_out 8 cycles after start edge.
REQ-035 Default order, n_key=0xFF, byte 0xA5 then eot -> fme_data 0x25 then padded 0x01, then done.
REQ-036 MSB_FIRST_EN, same stimulus -> fme_data 0x52 then 0x40, then done.
REQ-037 n_key=1 -> err pulse, no start_out, back to IDLE; n_key=0 same.
REQ-038 fme_ready held low 20 cycles in ISSUE -> no fme_start, fme_data stable; fme_start one cycle after fme_ready rises.
REQ-039 rst low mid-PACK -> all outputs 0 that cycle, busy low; new message afterwards packs correctly.

Source files
------------

// File: rtl/block_packer.sv
// block_packer: measures the bit length of a modulus, then packs received
// bytes into (n_len-1)-bit blocks and hands each one to a modular
// exponentiator with a ready/start handshake.
// Optional build macro BLOCK_PACKER_MSB_FIRST_EN: bytes are consumed MSB
// first and blocks fill from their top bit down.

module block_packer #(
    parameter int KEY_W  = 32,
    parameter int BYTE_W = 8,
    parameter int LEN_W  = $clog2(KEY_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  n_key,
    input  logic              ready_in,
    input  logic              eot_in,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              fme_ready,
    output logic              clear_rx_flag,
    output logic              start_out,
    output logic [LEN_W-1:0]  n_len_out,
    output logic [LEN_W-1:0]  blk_len_out,
    output logic              fme_start,
    output logic [KEY_W-1:0]  fme_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BCW = $clog2(BYTE_W + 1);

    typedef enum logic [1:0] {IDLE, SIZING, PACK, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [LEN_W-1:0]  n_len_q, n_len_d;
    logic [LEN_W-1:0]  blk_len_q, blk_len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [KEY_W-1:0]  acc_q, acc_d;
    logic              eot_q, eot_d;
    logic [KEY_W-1:0]  fme_data_q, fme_data_d;
    logic              clear_q, clear_d;
    logic              start_out_q, start_out_d;
    logic              fme_start_q, fme_start_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              take_bit;
    logic              bit_v;
    logic [BYTE_W-1:0] byte_src;
    logic [BYTE_W-1:0] byte_shift;
    logic [LEN_W-1:0]  bit_pos;
    logic [LEN_W-1:0]  len_fin;

    // Register bank: FSM state, datapath and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset clears every register asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            n_len_q     <= '0;
            blk_len_q   <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            bcnt_q      <= '0;
            acc_q       <= '0;
            eot_q       <= 1'b0;
            fme_data_q  <= '0;
            clear_q     <= 1'b0;
            start_out_q <= 1'b0;
            fme_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            n_len_q     <= n_len_d;
            blk_len_q   <= blk_len_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            bcnt_q      <= bcnt_d;
            acc_q       <= acc_d;
            eot_q       <= eot_d;
            fme_data_q  <= fme_data_d;
            clear_q     <= clear_d;
            start_out_q <= start_out_d;
            fme_start_q <= fme_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-datapath logic for sizing, packing and issuing.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        n_len_d     = n_len_q;
        blk_len_d   = blk_len_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        bcnt_d      = bcnt_q;
        acc_d       = acc_q;
        eot_d       = eot_q;
        fme_data_d  = fme_data_q;
        clear_d     = 1'b0;
        start_out_d = 1'b0;
        fme_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        take_bit    = 1'b0;
        len_fin     = n_len_q + LEN_W'(key_q[0]);

        // A fresh byte is consumed straight from data_in in its load cycle.
        byte_src = (bcnt_q == '0) ? data_in : byte_q;
`ifdef BLOCK_PACKER_MSB_FIRST_EN
        bit_v      = byte_src[BYTE_W-1];
        byte_shift = byte_src << 1;
        bit_pos    = blk_len_q - cnt_q - LEN_W'(1);
`else
        bit_v      = byte_src[0];
        byte_shift = byte_src >> 1;
        bit_pos    = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d     = n_key;
                    n_len_d   = '0;
                    blk_len_d = '0;
                    cnt_d     = '0;
                    bcnt_d    = '0;
                    acc_d     = '0;
                    eot_d     = 1'b0;
                    clear_d   = 1'b1;
                    state_d   = SIZING;
                end
            end
            SIZING: begin
                // Finish in the cycle the last set bit is counted.
                if (key_q[KEY_W-1:1] == '0) begin
                    n_len_d = len_fin;
                    if (len_fin < LEN_W'(2)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        start_out_d = 1'b1;
                        blk_len_d   = len_fin - LEN_W'(1);
                        state_d     = PACK;
                    end
                end else begin
                    key_d   = key_q >> 1;
                    n_len_d = n_len_q + LEN_W'(1);
                end
            end
            PACK: begin
                if (bcnt_q != '0) begin
                    take_bit = 1'b1;
                    bcnt_d   = bcnt_q - BCW'(1);
                end else if (ready_in) begin
                    take_bit = 1'b1;
                    clear_d  = 1'b1;
                    bcnt_d   = BCW'(BYTE_W - 1);
                end else if (eot_in) begin
                    clear_d = 1'b1;
                    if (cnt_q != '0) begin
                        // Unfilled positions are already zero: padding is free.
                        eot_d   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (take_bit) begin
                    byte_d = byte_shift;
                    acc_d  = acc_q | (KEY_W'(bit_v) << bit_pos);
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == blk_len_q) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (fme_ready) begin
                    fme_start_d = 1'b1;
                    fme_data_d  = acc_q;
                    acc_d       = '0;
                    cnt_d       = '0;
                    if (eot_q) begin
                        done_d  = 1'b1;
                        eot_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = PACK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign clear_rx_flag = clear_q;
    assign start_out     = start_out_q;
    assign n_len_out     = n_len_q;
    assign blk_len_out   = blk_len_q;
    assign fme_start     = fme_start_q;
    assign fme_data      = fme_data_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: directed cases with literal
// expectations plus randomized messages checked against a bit-stream model.
// Honours BLOCK_PACKER_MSB_FIRST_EN the same way the design does.

module tb_block_packer;

    localparam int KEY_W  = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = $clog2(KEY_W + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KEY_W-1:0]  n_key;
    logic              ready_in;
    logic              eot_in;
    logic [BYTE_W-1:0] data_in;
    logic              fme_ready;
    logic              clear_rx_flag;
    logic              start_out;
    logic [LEN_W-1:0]  n_len_out;
    logic [LEN_W-1:0]  blk_len_out;
    logic              fme_start;
    logic [KEY_W-1:0]  fme_data;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic              rand_en   = 1'b0;
    logic              rand_bit  = 1'b0;
    logic              force_bit = 1'b0;
    assign fme_ready = rand_en ? rand_bit : force_bit;

    logic [BYTE_W-1:0] tx_q[$];
    logic              tx_eot = 1'b0;
    logic [BYTE_W-1:0] msg[$];
    logic [KEY_W-1:0]  exp_q[$];
    int                cur_l = 1;
    int                done_cnt = 0;
    logic [KEY_W-1:0]  last_data = '0;

    block_packer #(.KEY_W(KEY_W), .BYTE_W(BYTE_W), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .n_key         (n_key),
        .ready_in      (ready_in),
        .eot_in        (eot_in),
        .data_in       (data_in),
        .fme_ready     (fme_ready),
        .clear_rx_flag (clear_rx_flag),
        .start_out     (start_out),
        .n_len_out     (n_len_out),
        .blk_len_out   (blk_len_out),
        .fme_start     (fme_start),
        .fme_data      (fme_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bit length of a key: index of its highest set bit plus one.
    function automatic int model_nlen(input logic [KEY_W-1:0] key);
        int n = 0;
        for (int i = 0; i < KEY_W; i++) if (key[i]) n = i + 1;
        return n;
    endfunction

    // Flatten msg into a bit stream and cut it into L-bit zero-padded blocks.
    task automatic model_blocks(input int l);
        bit stream[$];
        foreach (msg[b]) begin
            for (int k = 0; k < BYTE_W; k++) begin
`ifdef BLOCK_PACKER_MSB_FIRST_EN
                stream.push_back(msg[b][BYTE_W-1-k]);
`else
                stream.push_back(msg[b][k]);
`endif
            end
        end
        while (stream.size() > 0) begin
            logic [KEY_W-1:0] blk = '0;
            for (int j = 0; j < l && stream.size() > 0; j++) begin
`ifdef BLOCK_PACKER_MSB_FIRST_EN
                blk[l-1-j] = stream.pop_front();
`else
                blk[j] = stream.pop_front();
`endif
            end
            exp_q.push_back(blk);
        end
    endtask

    // RX source: presents one byte (or eot) and holds it until acknowledged.
    initial begin
        int gap = 0;
        ready_in = 1'b0;
        eot_in   = 1'b0;
        data_in  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ready_in = 1'b0;
                eot_in   = 1'b0;
            end else if (ready_in || eot_in) begin
                if (clear_rx_flag) begin
                    ready_in = 1'b0;
                    eot_in   = 1'b0;
                    gap      = $urandom_range(0, 2);
                end
            end else if (gap > 0) begin
                gap--;
            end else if (tx_q.size() > 0) begin
                data_in  = tx_q.pop_front();
                ready_in = 1'b1;
            end else if (tx_eot) begin
                eot_in = 1'b1;
                tx_eot = 1'b0;
            end
        end
    end

    // Random exponentiator readiness.
    initial begin
        forever begin
            @(negedge clk);
            rand_bit = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: block values, upper-bit zeroing, hand-off stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_data = '0;
            end else begin
                if (done) done_cnt++;
                if (fme_start) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_fme_start", 1, 0);
                    end else begin
                        check("fme_data", fme_data, exp_q.pop_front());
                    end
                    check("fme_data_upper_zero", 64'(fme_data) >> cur_l, 0);
                    last_data = fme_data;
                end else if (busy) begin
                    check("fme_data_stable", fme_data, last_data);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_clear_rx_flag"}, clear_rx_flag, 0);
        check({tag, "_start_out"}, start_out, 0);
        check({tag, "_n_len_out"}, n_len_out, 0);
        check({tag, "_blk_len_out"}, blk_len_out, 0);
        check({tag, "_fme_start"}, fme_start, 0);
        check({tag, "_fme_data"}, fme_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic size_key(input logic [KEY_W-1:0] key, input int exp_n);
        int found_k = 0;
        @(negedge clk);
        n_key = key;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_key = $urandom;
        check("start_ack_clear_rx", clear_rx_flag, 1);
        check("busy_in_sizing", busy, 1);
        for (int k = 1; k <= 2 * KEY_W + 4; k++) begin
            @(negedge clk);
            if (start_out || err) begin
                found_k = k;
                break;
            end
        end
        check("sizing_completes", found_k != 0, 1);
        if (exp_n >= 2) begin
            check("start_out_latency", found_k, exp_n);
            check("start_out_pulse", start_out, 1);
            check("no_err_good_key", err, 0);
            check("n_len_out", n_len_out, exp_n);
            check("blk_len_out", blk_len_out, exp_n - 1);
        end else begin
            check("err_pulse", err, 1);
            check("no_start_out_bad_key", start_out, 0);
            @(negedge clk);
            check("err_one_cycle", err, 0);
            check("idle_after_err", busy, 0);
        end
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        check("blocks_outstanding", exp_q.size(), 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic run_message(input logic [KEY_W-1:0] key, input int nbytes);
        int n = model_nlen(key);
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(BYTE_W'($urandom));
        cur_l = n - 1;
        model_blocks(n - 1);
        size_key(key, n);
        foreach (msg[i]) tx_q.push_back(msg[i]);
        tx_eot = 1'b1;
        wait_done(3000);
    endtask

    initial begin
        logic [KEY_W-1:0] exp0;
        logic [KEY_W-1:0] exp1;
        int seen_start;
        rst   = 1'b0;
        start = 1'b0;
        n_key = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // 0xFF: 8-bit key, 7-bit blocks; 0xA5 then eot; exponentiator stalls.
`ifdef BLOCK_PACKER_MSB_FIRST_EN
        exp0 = 32'h52;
        exp1 = 32'h40;
`else
        exp0 = 32'h25;
        exp1 = 32'h01;
`endif
        rand_en   = 1'b0;
        force_bit = 1'b0;
        size_key(32'h0000_00FF, 8);
        cur_l = 7;
        exp_q.push_back(exp0);
        exp_q.push_back(exp1);
        tx_q.push_back(8'hA5);
        tx_eot = 1'b1;
        seen_start = 0;
        repeat (30) begin
            @(negedge clk);
            if (fme_start) seen_start++;
        end
        check("no_fme_start_while_not_ready", seen_start, 0);
        check("busy_while_stalled", busy, 1);
        force_bit = 1'b1;
        @(negedge clk);
        check("fme_start_after_ready", fme_start, 1);
        check("first_block_literal", fme_data, exp0);
        wait_done(200);
        check("last_block_literal", fme_data, exp1);

        // Keys too short to form a block.
        size_key(32'h0000_0001, 1);
        size_key(32'h0000_0000, 0);

        // Reset in the middle of packing, then a fresh message.
        size_key(32'h0000_FFFF, 16);
        cur_l = 15;
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h5A);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_pack_reset");
        tx_q.delete();
        tx_eot = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_message(32'h0000_FFFF, 3);

        // Widest key and the narrowest usable key.
        run_message(32'hFFFF_FFFF, 5);
        run_message(32'h0000_0002, 2);

        // Randomized messages against the bit-stream model.
        rand_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            int nbits = $urandom_range(2, KEY_W);
            logic [63:0] mask = (64'd1 << nbits) - 64'd1;
            logic [63:0] r = {$urandom, $urandom} & mask;
            logic [KEY_W-1:0] key = KEY_W'(r) | (KEY_W'(1) << (nbits - 1));
            run_message(key, $urandom_range(0, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #900_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, expected completion before 900000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
